// File: rtl/est_weight_update_if.sv
// Handshake and data bundle for est_weight_update.
// master: the side that issues start and feeds dot-product results.
// slave:  the weight-update engine.
interface est_weight_update_if #(
    parameter int DATA_WIDTH = 16,
    parameter int EXT_DIM    = 4
);
    logic                          start;
    logic [DATA_WIDTH*EXT_DIM-1:0] weight_vec;
    logic                          dot_valid;
    logic [DATA_WIDTH-1:0]         dot_in;
    logic [DATA_WIDTH*EXT_DIM-1:0] sample_vec;
    logic                          dot_ready;
    logic                          busy;
    logic [DATA_WIDTH*EXT_DIM-1:0] w_new;
    logic                          done;

    modport master (
        output start, weight_vec, dot_valid, dot_in, sample_vec,
        input  dot_ready, busy, w_new, done
    );

    modport slave (
        input  start, weight_vec, dot_valid, dot_in, sample_vec,
        output dot_ready, busy, w_new, done
    );
endinterface

// File: rtl/est_weight_update.sv
// est_weight_update: one fixed-point FastICA-style weight update,
//   w_new = E{x*y^3} - E{3*y^2}*w, over 2^LOG2_NSAMP samples.
// Each sample passes through CUBE1 (y^2), CUBE2 (y^3) and EXT_DIM ACC
// cycles; FINAL then emits one output element per cycle.
// Optional build macro EST_WUPD_SAT_EN: g and w_new saturate to the
// DATA_WIDTH signed range instead of wrapping to the low bits.
module est_weight_update #(
    parameter int DATA_WIDTH = 16,
    parameter int EXT_DIM    = 4,
    parameter int FRAC_BITS  = 12,
    parameter int ACC_WIDTH  = 40,
    parameter int LOG2_NSAMP = 8
) (
    input  logic               clk,
    input  logic               rst,
    est_weight_update_if.slave bus
);

    localparam int P2    = 2 * DATA_WIDTH;
    localparam int P3    = 3 * DATA_WIDTH;
    localparam int PW    = ACC_WIDTH + DATA_WIDTH;
    localparam int SW    = (PW + 1 > P3) ? PW + 1 : P3;
    localparam int IDX_W = (EXT_DIM > 1) ? $clog2(EXT_DIM) : 1;
    localparam int CW    = LOG2_NSAMP + 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(EXT_DIM - 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'((1 << LOG2_NSAMP) - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DOT,
        CUBE1,
        CUBE2,
        ACC,
        FINAL,
        DONE
    } state_t;

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic [CW-1:0]                   cnt;
    logic signed [DATA_WIDTH-1:0]    y_reg;
    logic [DATA_WIDTH*EXT_DIM-1:0]   x_reg;
    logic signed [P2-1:0]            y2_reg;
    logic signed [DATA_WIDTH-1:0]    g_reg;
    logic signed [ACC_WIDTH-1:0]     gp_acc;
    logic signed [ACC_WIDTH-1:0]     acc [EXT_DIM];
    logic [DATA_WIDTH*EXT_DIM-1:0]   w_new_r;
    logic                            dot_ready_r;
    logic                            busy_r;
    logic                            done_r;

    logic signed [DATA_WIDTH-1:0]    x_el;
    logic signed [DATA_WIDTH-1:0]    w_el;
    logic signed [DATA_WIDTH-1:0]    g_next;
    logic signed [DATA_WIDTH-1:0]    wn_el;
    logic signed [P2-1:0]            y2_next;
    logic signed [ACC_WIDTH-1:0]     acc_sel;
    logic signed [ACC_WIDTH-1:0]     m_val;
    logic signed [ACC_WIDTH-1:0]     gp_mean;

`ifdef EST_WUPD_SAT_EN
    // Clamp a wide signed value into the DATA_WIDTH signed range: in range
    // exactly when every bit above the DATA_WIDTH sign bit copies it.
    function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [SW-1:0] v);
        if (v[SW-1:DATA_WIDTH-1] == {(SW-DATA_WIDTH+1){v[SW-1]}})
            return v[DATA_WIDTH-1:0];
        else if (v[SW-1])
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction
`endif

    // Datapath: element selection, square, cube and final combine.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every
        // path (here unconditionally), so no latch can be inferred.
        x_el    = x_reg[(EXT_DIM-1-int'(idx))*DATA_WIDTH +: DATA_WIDTH];
        w_el    = bus.weight_vec[(EXT_DIM-1-int'(idx))*DATA_WIDTH +: DATA_WIDTH];
        acc_sel = acc[idx];
        y2_next = (P2'(y_reg) * P2'(y_reg)) >>> FRAC_BITS;
        m_val   = acc_sel >>> (FRAC_BITS + LOG2_NSAMP);
        gp_mean = gp_acc >>> LOG2_NSAMP;
`ifdef EST_WUPD_SAT_EN
        g_next  = sat_dw(SW'((P3'(y2_reg) * P3'(y_reg)) >>> FRAC_BITS));
        wn_el   = sat_dw(SW'(m_val) - SW'((PW'(gp_mean) * PW'(w_el)) >>> FRAC_BITS));
`else
        g_next  = DATA_WIDTH'((P3'(y2_reg) * P3'(y_reg)) >>> FRAC_BITS);
        wn_el   = DATA_WIDTH'(PW'(m_val) - ((PW'(gp_mean) * PW'(w_el)) >>> FRAC_BITS));
`endif
    end

    // Control FSM with registered outputs, accumulators and result register.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            y_reg       <= '0;
            x_reg       <= '0;
            y2_reg      <= '0;
            g_reg       <= '0;
            gp_acc      <= '0;
            // NOTE: the accumulator array is reset explicitly because a
            // reset must discard any partial batch; plain storage arrays
            // would normally be left unreset.
            for (int i = 0; i < EXT_DIM; i++) acc[i] <= '0;
            w_new_r     <= '0;
            dot_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < EXT_DIM; i++) acc[i] <= '0;
                        gp_acc      <= '0;
                        cnt         <= '0;
                        idx         <= '0;
                        busy_r      <= 1'b1;
                        dot_ready_r <= 1'b1;
                        state       <= WAIT_DOT;
                    end
                end
                WAIT_DOT: begin
                    if (bus.dot_valid) begin
                        y_reg       <= bus.dot_in;
                        x_reg       <= bus.sample_vec;
                        dot_ready_r <= 1'b0;
                        state       <= CUBE1;
                    end
                end
                CUBE1: begin
                    y2_reg <= y2_next;
                    gp_acc <= gp_acc + ACC_WIDTH'(y2_next) + (ACC_WIDTH'(y2_next) <<< 1);
                    state  <= CUBE2;
                end
                CUBE2: begin
                    g_reg <= g_next;
                    idx   <= '0;
                    state <= ACC;
                end
                ACC: begin
                    acc[idx] <= acc[idx] + ACC_WIDTH'(P2'(x_el) * P2'(g_reg));
                    if (idx == IDX_LAST) begin
                        idx <= '0;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= FINAL;
                        end else begin
                            dot_ready_r <= 1'b1;
                            state       <= WAIT_DOT;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINAL: begin
                    w_new_r[(EXT_DIM-1-int'(idx))*DATA_WIDTH +: DATA_WIDTH] <= wn_el;
                    if (idx == IDX_LAST) begin
                        idx    <= '0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    dot_ready_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.dot_ready = dot_ready_r;
    assign bus.busy      = busy_r;
    assign bus.w_new     = w_new_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_est_weight_update.sv
// Directed bench for est_weight_update. dut0 runs single-sample batches
// (LOG2_NSAMP=0), dut1 two-sample batches (LOG2_NSAMP=1); both share the
// same stimulus wires and each test looks at the instance it targets.
module tb_est_weight_update;

    localparam int DW = 16;
    localparam int ED = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   weight_vec = '0;
    logic          dot_valid = 1'b0;
    logic [15:0]   dot_in = '0;
    logic [63:0]   sample_vec = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    est_weight_update_if #(.DATA_WIDTH(DW), .EXT_DIM(ED)) if0 ();
    est_weight_update_if #(.DATA_WIDTH(DW), .EXT_DIM(ED)) if1 ();

    assign if0.start      = start;
    assign if0.weight_vec = weight_vec;
    assign if0.dot_valid  = dot_valid;
    assign if0.dot_in     = dot_in;
    assign if0.sample_vec = sample_vec;
    assign if1.start      = start;
    assign if1.weight_vec = weight_vec;
    assign if1.dot_valid  = dot_valid;
    assign if1.dot_in     = dot_in;
    assign if1.sample_vec = sample_vec;

    est_weight_update #(
        .DATA_WIDTH(DW), .EXT_DIM(ED), .FRAC_BITS(12), .ACC_WIDTH(40), .LOG2_NSAMP(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );

    est_weight_update #(
        .DATA_WIDTH(DW), .EXT_DIM(ED), .FRAC_BITS(12), .ACC_WIDTH(40), .LOG2_NSAMP(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic do_reset();
        start = 1'b0; dot_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One single-sample batch on dut0 with dot_valid offered alongside start.
    task automatic run_single(input string name, input logic [63:0] w, input int y,
                              input logic [63:0] x, input logic [63:0] exp_w);
        int  n;
        bit  seen;
        weight_vec = w; dot_in = 16'(y); sample_vec = x;
        start = 1'b1; dot_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0;
        tests_run++;
        if (if0.dot_ready !== 1'b1 || if0.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_wait: dot_ready=%b busy=%b, expected 1 1", name, if0.dot_ready, if0.busy);
        end
        @(posedge clk); #1;
        dot_valid = 1'b0; n = 1;
        tests_run++;
        if (if0.dot_ready !== 1'b0 || if0.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept: dot_ready=%b busy=%b, expected 0 1", name, if0.dot_ready, if0.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (if0.done === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n != 11) begin
            tests_failed++;
            $display("FAIL %s_latency: done seen=%0d after %0d cycles, expected 11", name, seen, n);
        end
        tests_run++;
        if (if0.w_new !== exp_w) begin
            tests_failed++;
            $display("FAIL %s_w_new: got %h, expected %h", name, if0.w_new, exp_w);
        end
        @(posedge clk); #1;
        tests_run++;
        if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.w_new !== exp_w) begin
            tests_failed++;
            $display("FAIL %s_after: done=%b busy=%b w_new=%h, expected 0 0 %h",
                     name, if0.done, if0.busy, if0.w_new, exp_w);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (if0.dot_ready !== 1'b0 || if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: dot_ready=%b busy=%b done=%b, expected 0 0 0",
                     if0.dot_ready, if0.busy, if0.done);
        end
        tests_run++;
        if (if0.w_new !== 64'h0 || if1.w_new !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_w_new: got %h / %h, expected 0", if0.w_new, if1.w_new);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_single("basic", pack4(0, 0, 0, 0), 4096, pack4(4096, 0, 0, 0), pack4(4096, 0, 0, 0));
    endtask

    task automatic test_weight_term();
        do_reset();
        run_single("weight", pack4(4096, 0, 0, 0), 4096, pack4(4096, 0, 0, 0), pack4(-8192, 0, 0, 0));
    endtask

    task automatic test_overflow();
        logic [63:0] exp_w;
`ifdef EST_WUPD_SAT_EN
        exp_w = pack4(32767, 0, 0, 0);
`else
        exp_w = pack4(0, 0, 0, 0);
`endif
        do_reset();
        run_single("overflow", pack4(0, 0, 0, 0), 16384, pack4(4096, 0, 0, 0), exp_w);
    endtask

    // Two-sample batch on dut1; gp mean 12288 shows through the w term.
    task automatic test_two_samples(input string name, input logic [63:0] w, input logic [63:0] exp_w);
        bit seen;
        int n;
        do_reset();
        weight_vec = w; dot_in = 16'(4096); sample_vec = pack4(4096, 0, 0, 0);
        start = 1'b1; dot_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dot_valid = 1'b0;
        seen = 1'b0; n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (if1.dot_ready === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n != 6) begin
            tests_failed++;
            $display("FAIL %s_resume: dot_ready seen=%0d after %0d cycles, expected 6", name, seen, n);
        end
        dot_in = 16'(-4096); sample_vec = pack4(-4096, 0, 0, 0); dot_valid = 1'b1;
        @(posedge clk); #1;
        dot_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (if1.done === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_done: done never seen, expected pulse", name);
        end
        tests_run++;
        if (if1.w_new !== exp_w) begin
            tests_failed++;
            $display("FAIL %s_w_new: got %h, expected %h", name, if1.w_new, exp_w);
        end
    endtask

    // Second start and stray dot_valid while dut0 is in CUBE1.
    task automatic test_ignore();
        bit seen;
        int n;
        logic [63:0] exp_w;
        exp_w = pack4(-8192, 0, 0, 0);
        do_reset();
        weight_vec = pack4(4096, 0, 0, 0); dot_in = 16'(4096); sample_vec = pack4(4096, 0, 0, 0);
        start = 1'b1; dot_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0;
        @(posedge clk); #1;
        n = 1;
        start = 1'b1; dot_valid = 1'b1;
        dot_in = 16'(8192); sample_vec = pack4(8192, 4096, 4096, 4096);
        @(posedge clk); #1;
        n = 2;
        start = 1'b0; dot_valid = 1'b0;
        tests_run++;
        if (if0.busy !== 1'b1 || if0.dot_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_state: busy=%b dot_ready=%b, expected 1 0", if0.busy, if0.dot_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (if0.done === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n != 11) begin
            tests_failed++;
            $display("FAIL ignore_latency: done seen=%0d after %0d cycles, expected 11", seen, n);
        end
        tests_run++;
        if (if0.w_new !== exp_w) begin
            tests_failed++;
            $display("FAIL ignore_w_new: got %h, expected %h", if0.w_new, exp_w);
        end
    endtask

    // Reset during ACC, then a fresh batch.
    task automatic test_reset_mid();
        weight_vec = pack4(4096, 0, 0, 0); dot_in = 16'(4096); sample_vec = pack4(4096, 0, 0, 0);
        start = 1'b1; dot_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dot_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (if0.busy !== 1'b0 || if0.dot_ready !== 1'b0 || if0.done !== 1'b0 || if1.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_ctrl: busy=%b dot_ready=%b done=%b busy1=%b, expected 0 0 0 0",
                     if0.busy, if0.dot_ready, if0.done, if1.busy);
        end
        tests_run++;
        if (if0.w_new !== 64'h0 || if1.w_new !== 64'h0) begin
            tests_failed++;
            $display("FAIL midreset_w_new: got %h / %h, expected 0", if0.w_new, if1.w_new);
        end
        rst = 1'b0;
        run_single("after_reset", pack4(0, 0, 0, 0), 4096, pack4(4096, 0, 0, 0), pack4(4096, 0, 0, 0));
    endtask

    // Consecutive batches; each start must clear the previous accumulators.
    task automatic test_back_to_back();
        do_reset();
        run_single("b2b_a", pack4(0, 0, 0, 0), -4096, pack4(0, 4096, 0, 0), pack4(0, -4096, 0, 0));
        run_single("b2b_b", pack4(0, 0, 4096, -4096), 4096, pack4(0, 0, 0, 2048),
                   pack4(0, 0, -12288, 14336));
        run_single("b2b_c", pack4(0, 0, 0, 0), 2048, pack4(4096, 0, 0, 0), pack4(512, 0, 0, 0));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_weight_term();
        test_overflow();
        test_two_samples("two_w0", pack4(0, 0, 0, 0), pack4(4096, 0, 0, 0));
        test_two_samples("two_w1", pack4(4096, 0, 0, 0), pack4(-8192, 0, 0, 0));
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
